// File: rtl/aes128_add_round_key.sv
// rtl/aes128_add_round_key.sv - AES-128 AddRoundKey stage: bulk XOR or byte-streamed collect with arrival tracking
module aes128_add_round_key (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic         bypass_i,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   byte_data_i,
    input  logic [3:0]   byte_addr_i,
    input  logic         byte_valid_i,
    input  logic         upstream_done_i,
    output logic [127:0] state_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BULK,
        S_COLLECT,
        S_DONE
    } fsm_t;

    fsm_t         r_fsm;
    logic [127:0] r_state;
    logic [15:0]  r_mask;
    logic         r_error;

    logic [6:0]   w_bit_base;
    logic [7:0]   w_key_byte;
    logic [15:0]  w_addr_onehot;
    logic [15:0]  w_mask_next;
    logic         w_dup;

    always_comb begin
        w_bit_base    = {byte_addr_i, 3'b000};
        w_key_byte    = key_i[w_bit_base +: 8];
        w_addr_onehot = 16'd1 << byte_addr_i;
        w_mask_next   = r_mask | (byte_valid_i ? w_addr_onehot : 16'd0);
        w_dup         = byte_valid_i && r_mask[byte_addr_i];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fsm   <= S_IDLE;
            r_state <= 128'd0;
            r_mask  <= 16'd0;
            r_error <= 1'b0;
        end else begin
            unique case (r_fsm)
                S_IDLE: begin
                    if (start_i) begin
                        r_mask  <= 16'd0;
                        r_error <= 1'b0;
                        r_fsm   <= bypass_i ? S_BULK : S_COLLECT;
                    end
                end
                S_BULK: begin
                    r_state <= data_i ^ key_i;
                    r_fsm   <= S_DONE;
                end
                S_COLLECT: begin
                    if (byte_valid_i) begin
                        r_state[w_bit_base +: 8] <= byte_data_i ^ w_key_byte;
                        r_mask                   <= w_mask_next;
                        if (w_dup) begin
                            r_error <= 1'b1;
                        end
                    end
                    // A byte landing together with upstream done counts toward completeness first.
                    if (w_mask_next == 16'hFFFF) begin
                        r_fsm <= S_DONE;
                    end else if (upstream_done_i) begin
                        r_error <= 1'b1;
                        r_fsm   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_fsm <= S_IDLE;
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign busy_o  = (r_fsm == S_BULK) || (r_fsm == S_COLLECT);
    assign done_o  = (r_fsm == S_DONE);
    assign error_o = r_error;

endmodule

// File: tb/tb_aes128_add_round_key.sv
// tb/tb_aes128_add_round_key.sv - directed self-checking bench for aes128_add_round_key
module tb_aes128_add_round_key;

    logic         clk_i;
    logic         rst_n_i;
    logic         start_i;
    logic         bypass_i;
    logic [127:0] data_i;
    logic [127:0] key_i;
    logic [7:0]   byte_data_i;
    logic [3:0]   byte_addr_i;
    logic         byte_valid_i;
    logic         upstream_done_i;
    logic [127:0] state_o;
    logic         busy_o;
    logic         done_o;
    logic         error_o;

    int checks = 0;
    int errors = 0;

    aes128_add_round_key dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .bypass_i        (bypass_i),
        .data_i          (data_i),
        .key_i           (key_i),
        .byte_data_i     (byte_data_i),
        .byte_addr_i     (byte_addr_i),
        .byte_valid_i    (byte_valid_i),
        .upstream_done_i (upstream_done_i),
        .state_o         (state_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
    } bulk_vec_t;

    bulk_vec_t vecs [4];

    // Constants are written in listing order (byte 0 first, leftmost); lv maps them onto the bus.
    localparam logic [127:0] R1_BYTES = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] R1_KEY   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] R1_EXP   = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
    localparam logic [127:0] INC_EXP  = 128'ha0fafe17_88542c2b_23a33939_2a6c7605;
    localparam logic [127:0] DUP_EXP  = 128'h00010222_04050607_08090a0b_0c0d0e0f;

    function automatic logic [127:0] lv(input logic [127:0] l);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = l[8*(15-k) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] lbyte(input logic [127:0] l, input int k);
        return l[8*(15-k) +: 8];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic byp);
        start_i  = 1'b1;
        bypass_i = byp;
        @(negedge clk_i);
        start_i  = 1'b0;
        bypass_i = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic [7:0] v, input logic fin);
        byte_valid_i    = 1'b1;
        byte_addr_i     = 4'(k);
        byte_data_i     = v;
        upstream_done_i = fin;
        @(negedge clk_i);
        byte_valid_i    = 1'b0;
        upstream_done_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{128'h3243f6a8_885a308d_313198a2_e0370734,
                    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                    128'h193de3be_a0f4e22b_9ac68d2a_e9f84808};
        vecs[1] = '{128'h0,
                    128'h00010203_04050607_08090a0b_0c0d0e0f,
                    128'h00010203_04050607_08090a0b_0c0d0e0f};
        vecs[2] = '{128'hffffffff_ffffffff_ffffffff_ffffffff,
                    128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f,
                    128'hf0f0f0f0_f0f0f0f0_f0f0f0f0_f0f0f0f0};
        vecs[3] = '{128'hdeadbeef_01234567_89abcdef_cafef00d,
                    128'hdeadbeef_01234567_89abcdef_cafef00d,
                    128'h0};

        rst_n_i = 1'b0; start_i = 1'b0; bypass_i = 1'b0;
        data_i = '0; key_i = '0; byte_data_i = '0; byte_addr_i = '0;
        byte_valid_i = 1'b0; upstream_done_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_state", state_o, 128'h0);
        check("reset_busy", 128'(busy_o), 128'h0);
        check("reset_done", 128'(done_o), 128'h0);
        check("reset_error", 128'(error_o), 128'h0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Bytes in IDLE must be ignored.
        key_i = lv(R1_KEY);
        send_byte(0, 8'hff, 1'b1);
        check("idle_byte_ignored", state_o, 128'h0);
        check("idle_no_busy", 128'(busy_o), 128'h0);

        // Bulk vectors.
        for (int i = 0; i < 4; i++) begin
            data_i = lv(vecs[i].data);
            key_i  = lv(vecs[i].key);
            do_start(1'b1);
            check($sformatf("bulk%0d_busy", i), 128'(busy_o), 128'h1);
            check($sformatf("bulk%0d_early_done", i), 128'(done_o), 128'h0);
            @(negedge clk_i);
            check($sformatf("bulk%0d_done", i), 128'(done_o), 128'h1);
            check($sformatf("bulk%0d_state", i), state_o, lv(vecs[i].exp));
            check($sformatf("bulk%0d_error", i), 128'(error_o), 128'h0);
            @(negedge clk_i);
            check($sformatf("bulk%0d_done_pulse", i), 128'(done_o), 128'h0);
        end

        // Collect round 1, in order with gaps.
        data_i = '0;
        key_i  = lv(R1_KEY);
        do_start(1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                check("r1_not_done_before_last", 128'(done_o), 128'h0);
                check("r1_busy", 128'(busy_o), 128'h1);
            end
            send_byte(k, lbyte(R1_BYTES, k), 1'b0);
            if (k % 3 == 0 && k != 15) @(negedge clk_i);
        end
        check("r1_done", 128'(done_o), 128'h1);
        check("r1_state", state_o, lv(R1_EXP));
        check("r1_error", 128'(error_o), 128'h0);
        @(negedge clk_i);

        // Out of order, final byte together with upstream done.
        do_start(1'b0);
        for (int k = 15; k >= 0; k--) send_byte(k, lbyte(R1_BYTES, k), k == 0);
        check("ooo_done", 128'(done_o), 128'h1);
        check("ooo_state", state_o, lv(R1_EXP));
        check("ooo_error", 128'(error_o), 128'h0);
        @(negedge clk_i);

        // Incomplete stream: byte 7 missing, zero data so written bytes equal key bytes.
        do_start(1'b0);
        for (int k = 0; k < 16; k++) if (k != 7) send_byte(k, 8'h00, 1'b0);
        check("inc_not_done", 128'(done_o), 128'h0);
        upstream_done_i = 1'b1;
        @(negedge clk_i);
        upstream_done_i = 1'b0;
        check("inc_done", 128'(done_o), 128'h1);
        check("inc_error", 128'(error_o), 128'h1);
        check("inc_state", state_o, lv(INC_EXP));
        @(negedge clk_i);
        check("inc_error_sticky", 128'(error_o), 128'h1);

        // Duplicate write of byte 3 with a zero key.
        key_i = '0;
        do_start(1'b0);
        check("start_clears_error", 128'(error_o), 128'h0);
        send_byte(3, 8'h11, 1'b0);
        send_byte(3, 8'h22, 1'b0);
        check("dup_error", 128'(error_o), 128'h1);
        for (int k = 0; k < 16; k++) begin
            if (k != 3) send_byte(k, 8'(k), 1'b0);
            if (k == 14) check("dup_not_done", 128'(done_o), 128'h0);
        end
        check("dup_done", 128'(done_o), 128'h1);
        check("dup_state", state_o, lv(DUP_EXP));
        check("dup_error_held", 128'(error_o), 128'h1);
        @(negedge clk_i);

        // Asynchronous reset mid-collect.
        key_i = lv(R1_KEY);
        do_start(1'b0);
        for (int k = 0; k < 8; k++) send_byte(k, lbyte(R1_BYTES, k), 1'b0);
        #1 rst_n_i = 1'b0;
        #1;
        check("areset_state", state_o, 128'h0);
        check("areset_busy", 128'(busy_o), 128'h0);
        check("areset_error", 128'(error_o), 128'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Collect after reset, with a start pulse mid-stream that must be ignored.
        data_i = lv(vecs[2].data);
        do_start(1'b0);
        for (int k = 0; k < 8; k++) send_byte(k, lbyte(R1_BYTES, k), 1'b0);
        do_start(1'b1);
        check("mid_start_busy", 128'(busy_o), 128'h1);
        check("mid_start_no_done", 128'(done_o), 128'h0);
        for (int k = 8; k < 16; k++) send_byte(k, lbyte(R1_BYTES, k), 1'b0);
        check("post_reset_done", 128'(done_o), 128'h1);
        check("post_reset_state", state_o, lv(R1_EXP));
        check("post_reset_error", 128'(error_o), 128'h0);
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
